// File: rtl/ro_puf_eval.sv
// ro_puf_eval: ring-oscillator PUF evaluator.
// Races oscillator pairs over a gated window and returns response and tie bits.
module ro_puf_eval #(
    parameter int NUM_RO    = 16,
    parameter int CNT_W     = 16,
    parameter int WIN_W     = 16,
    parameter int RESP_BITS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic [NUM_RO-1:0]            osc_in,
    input  logic                         start,
    input  logic [2*$clog2(NUM_RO)-1:0]  challenge,
    input  logic [WIN_W-1:0]             win_len,
    output logic                         busy,
    output logic                         resp_valid,
    output logic [RESP_BITS-1:0]         resp,
    output logic [RESP_BITS-1:0]         tie_mask
);

    localparam int SEL_W = $clog2(NUM_RO);
    localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESP_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_COUNT = 3'd2;
    localparam logic [2:0] S_CMP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [NUM_RO-1:0]    sync1;
    logic [NUM_RO-1:0]    sync2;
    logic [NUM_RO-1:0]    hist;
    logic [NUM_RO-1:0]    rise;

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic                 accept;
    logic                 last_win;

    logic [SEL_W-1:0]     ch_a;
    logic [SEL_W-1:0]     ch_b;
    logic [SEL_W-1:0]     base_a;
    logic [SEL_W-1:0]     base_b;
    logic [SEL_W-1:0]     sel_a;
    logic [SEL_W-1:0]     sel_b;

    logic [WIN_W-1:0]     win_eff;
    logic [WIN_W-1:0]     win_cnt;
    logic [IDX_W-1:0]     race_idx;

    logic [CNT_W-1:0]     cnt_a;
    logic [CNT_W-1:0]     cnt_b;

    logic                 bit_res;
    logic                 bit_tie;
    logic [RESP_BITS-1:0] res_acc;
    logic [RESP_BITS-1:0] tie_acc;
    logic [RESP_BITS-1:0] res_nxt;
    logic [RESP_BITS-1:0] tie_nxt;

    assign ch_a     = challenge[SEL_W-1:0];
    assign ch_b     = challenge[2*SEL_W-1:SEL_W];
    assign accept   = (state == S_IDLE) && ena && start;
    assign rise     = sync2 & ~hist;
    assign last_win = (win_cnt == WIN_W'(1));

    // Bring the free-running oscillators into clk and keep one cycle of history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            sync1 <= osc_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // Sequencer: ena low from any active state drops straight back to idle.
    always_comb begin
        state_nxt = state;
        if (state != S_IDLE && !ena) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (accept) state_nxt = S_ARM;
                S_ARM:   state_nxt = S_COUNT;
                S_COUNT: if (last_win) state_nxt = S_CMP;
                S_CMP:   state_nxt = (race_idx == LAST_IDX) ? S_DONE : S_ARM;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Race outcome; a saturated counter makes the comparison meaningless.
    always_comb begin
        bit_res = (cnt_a > cnt_b);
        bit_tie = (cnt_a == cnt_b) || (cnt_a == CNT_MAX) || (cnt_b == CNT_MAX);
        res_nxt = res_acc;
        tie_nxt = tie_acc;
        if (state == S_CMP) begin
            res_nxt[race_idx] = bit_res;
            tie_nxt[race_idx] = bit_tie;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch challenge and window on accept; step the race index per compare.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_a   <= '0;
            base_b   <= '0;
            win_eff  <= '0;
            race_idx <= '0;
        end else if (accept) begin
            base_a   <= ch_a;
            base_b   <= (ch_b == ch_a) ? ch_a + SEL_W'(1) : ch_b;
            win_eff  <= (win_len == '0) ? WIN_W'(1) : win_len;
            race_idx <= '0;
        end else if (state == S_CMP) begin
            race_idx <= race_idx + IDX_W'(1);
        end
    end

    // Pair select, window countdown and saturating edge counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_a   <= '0;
            sel_b   <= '0;
            win_cnt <= '0;
            cnt_a   <= '0;
            cnt_b   <= '0;
        end else if (state == S_ARM) begin
            sel_a   <= base_a + SEL_W'(race_idx);
            sel_b   <= base_b + SEL_W'(race_idx);
            win_cnt <= win_eff;
            cnt_a   <= '0;
            cnt_b   <= '0;
        end else if (state == S_COUNT) begin
            win_cnt <= win_cnt - WIN_W'(1);
            if (rise[sel_a] && cnt_a != CNT_MAX) begin
                cnt_a <= cnt_a + CNT_W'(1);
            end
            if (rise[sel_b] && cnt_b != CNT_MAX) begin
                cnt_b <= cnt_b + CNT_W'(1);
            end
        end
    end

    // Partial results; dropped whenever the sequencer returns to idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_acc <= '0;
            tie_acc <= '0;
        end else if (state_nxt == S_IDLE) begin
            res_acc <= '0;
            tie_acc <= '0;
        end else if (state == S_CMP) begin
            res_acc <= res_nxt;
            tie_acc <= tie_nxt;
        end
    end

    // Registered outputs; the response is published on entry to DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp       <= '0;
            tie_mask   <= '0;
        end else begin
            busy       <= (state_nxt != S_IDLE);
            resp_valid <= (state_nxt == S_DONE);
            if (state_nxt == S_DONE) begin
                resp     <= res_nxt;
                tie_mask <= tie_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ro_puf_eval.sv
// tb_ro_puf_eval: directed bench for ro_puf_eval.
// Two instances: 1-bit response with 4-bit counters, and 3-bit response.
module tb_ro_puf_eval;

    localparam int NUM_RO = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic [NUM_RO-1:0] osc_in;
    logic              start_s;
    logic              start_3;
    logic [7:0]        challenge;
    logic [15:0]       win_len;

    logic              busy_s;
    logic              valid_s;
    logic [0:0]        resp_s;
    logic [0:0]        tie_s;
    logic              busy_3;
    logic              valid_3;
    logic [2:0]        resp_3;
    logic [2:0]        tie_3;

    int checks = 0;
    int errors = 0;
    int per [NUM_RO];
    int tick = 0;
    int cyc;
    int seen;

    always #5 clk = ~clk;

    ro_puf_eval #(
        .NUM_RO(NUM_RO), .CNT_W(4), .WIN_W(16), .RESP_BITS(1)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in),
        .start(start_s), .challenge(challenge), .win_len(win_len),
        .busy(busy_s), .resp_valid(valid_s), .resp(resp_s),
        .tie_mask(tie_s)
    );

    ro_puf_eval #(
        .NUM_RO(NUM_RO), .CNT_W(16), .WIN_W(16), .RESP_BITS(3)
    ) u_r3 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in),
        .start(start_3), .challenge(challenge), .win_len(win_len),
        .busy(busy_3), .resp_valid(valid_3), .resp(resp_3),
        .tie_mask(tie_3)
    );

    // Square-wave oscillator models; period 0 holds the line low.
    initial begin
        osc_in = '0;
        forever begin
            @(negedge clk);
            tick++;
            for (int k = 0; k < NUM_RO; k++) begin
                osc_in[k] = (per[k] > 0) && ((tick % per[k]) < per[k] / 2);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_pers();
        for (int k = 0; k < NUM_RO; k++) per[k] = 0;
    endtask

    // Returns mid-cycle 1 (the cycle after start is sampled).
    task automatic launch(input bit r3, input logic [3:0] a,
                          input logic [3:0] b, input logic [15:0] w);
        @(negedge clk);
        challenge = {b, a};
        win_len   = w;
        if (r3) start_3 = 1'b1;
        else    start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        start_3 = 1'b0;
    endtask

    task automatic wait_valid(input bit r3, output int n);
        n = 1;
        while (!(r3 ? valid_3 : valid_s) && n < 2000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ena = 1'b1;
        start_s = 1'b0;
        start_3 = 1'b0;
        challenge = '0;
        win_len = '0;
        clear_pers();
        repeat (3) @(negedge clk);
        check("rst_busy", {busy_3, busy_s}, 0);
        check("rst_valid", {valid_3, valid_s}, 0);
        check("rst_resp", {tie_3, resp_3, tie_s, resp_s}, 0);
        rst_n = 1'b1;

        // basic race: period 4 vs period 8, W=32
        per[0] = 4;
        per[1] = 8;
        repeat (40) @(negedge clk);
        launch(1'b0, 4'd0, 4'd1, 16'd32);
        check("t1_busy_c1", busy_s, 1);
        wait_valid(1'b0, cyc);
        check("t1_cycle", cyc, 35);
        check("t1_resp", resp_s, 1);
        check("t1_tie", tie_s, 0);
        check("t1_busy_done", busy_s, 1);
        @(negedge clk);
        check("t1_after", {busy_s, valid_s}, 0);

        // tie then reversal: races 2v3, 3v4, 4v5
        clear_pers();
        per[2] = 8;
        per[3] = 8;
        per[4] = 12;
        per[5] = 6;
        repeat (40) @(negedge clk);
        launch(1'b1, 4'd2, 4'd3, 16'd32);
        wait_valid(1'b1, cyc);
        check("t2_cycle", cyc, 103);
        check("t2_resp", resp_3, 3'b010);
        check("t2_tie", tie_3, 3'b001);

        // wrap with A==B: pairs (15,0), (0,1), (1,2)
        clear_pers();
        per[15] = 8;
        per[0] = 4;
        per[1] = 16;
        per[2] = 32;
        repeat (40) @(negedge clk);
        launch(1'b1, 4'd15, 4'd15, 16'd32);
        wait_valid(1'b1, cyc);
        check("t3_cycle", cyc, 103);
        check("t3_resp", resp_3, 3'b110);
        check("t3_tie", tie_3, 3'b000);

        // saturation: 50 edges into a 4-bit counter vs 12-13 edges
        clear_pers();
        per[0] = 4;
        per[1] = 16;
        repeat (40) @(negedge clk);
        launch(1'b0, 4'd0, 4'd1, 16'd200);
        wait_valid(1'b0, cyc);
        check("t4_cycle", cyc, 203);
        check("t4_resp", resp_s, 1);
        check("t4_tie", tie_s, 1);

        // abort mid-COUNT of race 1
        clear_pers();
        per[15] = 8;
        per[0] = 4;
        per[1] = 16;
        per[2] = 32;
        repeat (40) @(negedge clk);
        launch(1'b1, 4'd1, 4'd0, 16'd32);
        seen = 0;
        for (int n = 1; n < 40; n++) begin
            if (valid_3) seen++;
            @(negedge clk);
        end
        check("t5_busy_pre", busy_3, 1);
        ena = 1'b0;
        @(negedge clk);
        check("t5_busy_fall", busy_3, 0);
        repeat (5) begin
            if (valid_3) seen++;
            @(negedge clk);
        end
        check("t5_no_valid", seen, 0);
        check("t5_resp_kept", resp_3, 3'b110);
        check("t5_tie_kept", tie_3, 3'b000);
        ena = 1'b1;

        // fresh run with an ignored start and challenge change at cycle 50
        launch(1'b1, 4'd0, 4'd1, 16'd32);
        cyc = 1;
        while (!valid_3 && cyc < 2000) begin
            if (cyc == 50) begin
                challenge = 8'h01;
                start_3 = 1'b1;
            end else begin
                start_3 = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start_3 = 1'b0;
        check("t5_cycle", cyc, 103);
        check("t5_resp", resp_3, 3'b111);
        check("t5_tie", tie_3, 3'b000);

        // reset during COMPARE of race 0
        repeat (3) @(negedge clk);
        launch(1'b1, 4'd0, 4'd1, 16'd32);
        repeat (33) @(negedge clk);
        check("t6_busy_cmp", busy_3, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_busy", {busy_3, busy_s}, 0);
        check("t6_valid", {valid_3, valid_s}, 0);
        check("t6_resp", {tie_3, resp_3, tie_s, resp_s}, 0);

        // zero window behaves as W=1; idle oscillators all tie
        clear_pers();
        repeat (10) @(negedge clk);
        launch(1'b1, 4'd0, 4'd1, 16'd0);
        wait_valid(1'b1, cyc);
        check("t6_zw_cycle", cyc, 10);
        check("t6_zw_resp", resp_3, 3'b000);
        check("t6_zw_tie", tie_3, 3'b111);
        @(negedge clk);
        check("t6_zw_idle", {busy_3, valid_3}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
